// File: rtl/rs232c_tx_buffer_if.sv
// Dispatcher-side bundle of the RS232C transmit buffer: byte push strobe plus FIFO/line status.
interface rs232c_tx_buffer_if;
  logic       push_send_data;
  logic [7:0] send_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;

  modport master (
    output push_send_data,
    output send_data,
    input  full,
    input  empty,
    input  busy,
    input  overflow
  );

  modport slave (
    input  push_send_data,
    input  send_data,
    output full,
    output empty,
    output busy,
    output overflow
  );
endinterface

// File: rtl/rs232c_tx_buffer.sv
// RS232C transmit back end: byte FIFO feeding an 8N1 serializer on tx.
// Define RS232C_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module rs232c_tx_buffer #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rs232c_tx_buffer_if.slave   bus,
  output logic                tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

`ifdef RS232C_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;
`endif

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wptr_r, rptr_r, wptr_s, rptr_s;
  logic          full_r, empty_r, overflow_r, busy_r, tx_r;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bitidx_r;
  logic [7:0]    shift_r;
`ifdef RS232C_TX_PARITY_EN
  logic          parity_r;
`endif
  logic          pop_s, push_ok_s, drop_s, tx_s;
  logic [7:0]    head_s;

  // Pop/push arbitration and next-pointer computation.
  always_comb begin
    head_s = mem_r[rptr_r[DEPTH_LOG2-1:0]];
    pop_s  = 1'b0;
    if (!empty_r && (state_r == ST_IDLE)) begin
      pop_s = 1'b1;
    end else if (!empty_r && (state_r == ST_STOP) && (cnt_r == CNT_ZERO)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    // A full FIFO still accepts a push when a slot frees up on the same edge.
    push_ok_s = bus.push_send_data && (!full_r || pop_s);
    drop_s    = bus.push_send_data && full_r && !pop_s;
    wptr_s    = push_ok_s ? (wptr_r + PTR_ONE) : wptr_r;
    rptr_s    = pop_s ? (rptr_r + PTR_ONE) : rptr_r;
  end

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      ST_IDLE:   tx_s = 1'b1;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_r[0];
`ifdef RS232C_TX_PARITY_EN
      ST_PARITY: tx_s = parity_r;
`endif
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
  end

  // FIFO storage; flushing is done by resetting the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wptr_r[DEPTH_LOG2-1:0]] <= bus.send_data;
    end
  end

  // FIFO pointers, registered status flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r     <= PW'(0);
      rptr_r     <= PW'(0);
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      wptr_r     <= wptr_s;
      rptr_r     <= rptr_s;
      full_r     <= (wptr_s[DEPTH_LOG2] != rptr_s[DEPTH_LOG2]) &&
                    (wptr_s[DEPTH_LOG2-1:0] == rptr_s[DEPTH_LOG2-1:0]);
      empty_r    <= (wptr_s == rptr_s);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Serializer FSM with registered tx/busy (both lag the state by one edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      bitidx_r <= 3'd0;
      shift_r  <= 8'h00;
`ifdef RS232C_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= (state_r != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            shift_r <= head_s;
`ifdef RS232C_TX_PARITY_EN
            parity_r <= even_parity(head_s);
`endif
            cnt_r   <= CNT_LOAD;
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r    <= CNT_LOAD;
            bitidx_r <= 3'd0;
            state_r  <= ST_DATA;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r   <= CNT_LOAD;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bitidx_r == 3'd7) begin
`ifdef RS232C_TX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bitidx_r <= bitidx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`ifdef RS232C_TX_PARITY_EN
        ST_PARITY: begin
          if (cnt_r == CNT_ZERO) begin
            cnt_r   <= CNT_LOAD;
            state_r <= ST_STOP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_r == CNT_ZERO) begin
            if (pop_s) begin
              shift_r <= head_s;
`ifdef RS232C_TX_PARITY_EN
              parity_r <= even_parity(head_s);
`endif
              cnt_r   <= CNT_LOAD;
              state_r <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign tx           = tx_r;
  assign bus.full     = full_r;
  assign bus.empty    = empty_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_rs232c_tx_buffer.sv
// Randomized scoreboard bench for rs232c_tx_buffer: a queue-level line model predicts
// pops, flags and frame start times; a UART monitor decodes tx and checks against it.
module tb_rs232c_tx_buffer;
  localparam int CPB   = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef RS232C_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = NB * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   cyc   = 0;

  rs232c_tx_buffer_if bus();

  rs232c_tx_buffer #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] mq[$];      // bytes waiting in the FIFO
  logic [7:0] sb_q[$];    // bytes expected on the line, in order
  int         start_q[$]; // predicted cycle of each tx falling edge
  int         line_begin, line_end;
  bit         m_ovf;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    start_q.delete();
    line_begin = 0;
    line_end   = 0;
    m_ovf      = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled, then check flags.
  task automatic step();
    int  k;
    bit  pop, push, acc, mbusy;
    @(posedge clk);
    #1;
    k = cyc;
    if (!rst_n) begin
      model_reset();
      chk("rst_tx", tx, 1);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overflow", bus.overflow, 0);
    end else begin
      // The line pops once the previous frame's stop bit expires (one edge before line_end).
      pop  = (mq.size() > 0) && (k >= line_end - 1);
      push = bus.push_send_data;
      acc  = push && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        void'(mq.pop_front());
        start_q.push_back(k + 1);
        if (k + 1 > line_end) line_begin = k + 1;
        line_end = k + 1 + L;
      end
      if (acc) begin
        mq.push_back(bus.send_data);
        sb_q.push_back(bus.send_data);
      end
      if (push && !acc) m_ovf = 1'b1;
      mbusy = (k >= line_begin) && (k < line_end);
      chk("full", bus.full, (mq.size() == DEPTH) ? 1 : 0);
      chk("empty", bus.empty, (mq.size() == 0) ? 1 : 0);
      chk("busy", bus.busy, mbusy ? 1 : 0);
      chk("overflow", bus.overflow, m_ovf ? 1 : 0);
    end
  endtask

  task automatic drive(input bit p, input logic [7:0] d);
    bus.push_send_data = p;
    bus.send_data      = d;
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (((sb_q.size() > 0) || (cyc < line_end)) && (n < 20 * L * (DEPTH + 2))) begin
      drive(1'b0, 8'h00);
      n++;
    end
    if ((sb_q.size() > 0) || (cyc < line_end)) begin
      n_total++;
      $display("FAIL drain_timeout: %0d bytes still pending, required 0", sb_q.size());
    end
    repeat (4) drive(1'b0, 8'h00);
  endtask

  // Wait until the next edge is a predicted pop edge, bounded.
  task automatic wait_pop_edge();
    int n = 0;
    while ((cyc + 1 != line_end - 1) && (n < 2 * L)) begin
      drive(1'b0, 8'h00);
      n++;
    end
    if (cyc + 1 != line_end - 1) begin
      n_total++;
      $display("FAIL pop_wait: no pop edge found, cycle %0d line_end %0d", cyc, line_end);
    end
  endtask

  // UART monitor: decodes frames off tx and scores them against the model queues.
  initial begin : mon
    bit         act = 1'b0;
    int         st  = 0;
    int         off, b;
    logic       prev = 1'b1;
    logic [7:0] d = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        act  = 1'b0;
        prev = 1'b1;
      end else begin
        if (!act) begin
          if ((prev === 1'b1) && (tx === 1'b0)) begin
            act = 1'b1;
            st  = cyc;
            d   = 8'h00;
            if (start_q.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_frame: tx fell at cycle %0d, required no frame", cyc);
            end else begin
              chk("frame_start_cycle", cyc, start_q.pop_front());
            end
          end
        end else begin
          off = cyc - st;
          if ((off % CPB) == (CPB / 2)) begin
            b = off / CPB;
            if (b == 0) chk("start_bit", tx, 0);
            else if (b <= 8) d[b-1] = tx;
`ifdef RS232C_TX_PARITY_EN
            if (b == 9) chk("parity_bit", tx, ^d);
`endif
            if (b == NB - 1) begin
              chk("stop_bit", tx, 1);
              if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL frame_data: got %0h, required no frame", d);
              end else begin
                chk("frame_data", d, sb_q.pop_front());
              end
              act = 1'b0;
            end
          end
        end
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin : main
    model_reset();
    bus.push_send_data = 1'b0;
    bus.send_data      = 8'h00;
    rst_n              = 1'b0;
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (10) drive(1'b0, 8'h00);

    // Single byte, then a contiguous burst, then the parity corner bytes.
    drive(1'b1, 8'h55);
    wait_idle();
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    wait_idle();
    drive(1'b1, 8'h07);
    drive(1'b1, 8'h03);
    wait_idle();

    // 18 consecutive pushes: FIFO fills, the 18th is dropped.
    for (int i = 0; i < 18; i++) drive(1'b1, 8'($urandom));
    drive(1'b0, 8'h00);
    chk("fill_full", bus.full, 1);
    chk("fill_overflow", bus.overflow, 1);
    wait_idle();

    // Refill to 16 and push only on pop edges: accepted, no overflow.
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    step();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      wait_pop_edge();
      drive(1'b1, 8'($urandom));
      drive(1'b0, 8'h00);
      chk("samecycle_full", bus.full, 1);
      chk("samecycle_overflow", bus.overflow, 0);
    end
    wait_idle();

    // Reset in the middle of the data bits of 0x3C.
    drive(1'b1, 8'h3C);
    repeat (2 + 4 * CPB) drive(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_empty", bus.empty, 1);
    chk("midreset_busy", bus.busy, 0);
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (3 * L) drive(1'b0, 8'h00);

    // Sparse random traffic, then a dense burst that overflows.
    for (int i = 0; i < 600; i++) drive(($urandom_range(0, 7) == 0), 8'($urandom));
    wait_idle();
    for (int i = 0; i < 200; i++) drive(($urandom_range(0, 1) == 0), 8'($urandom));
    drive(1'b0, 8'h00);
    chk("dense_overflow", bus.overflow, 1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rs232c_tx_buffer.md
# rs232c_tx_buffer

Transmit back end of the RS232C path: accepts one-cycle byte pushes from the RS232C instruction dispatcher (`push_send_data`/`send_data`), queues them in a small FIFO, and serializes them onto the UART TX pin as 8N1 frames. It decouples back-to-back OUTPUTB instructions from the slow serial line. It sits between the dispatcher and the board-level `tx` pad.

## Interface
- `CLK_PER_BIT`, default 868, clocks per serial bit (100 MHz / 115200 baud); legal ≥ 2.
- `DEPTH_LOG2`, default 4, FIFO depth = 2^DEPTH_LOG2 bytes (16).
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `push_send_data`  in  1  one-cycle strobe: enqueue `send_data`.
- `send_data`  in  8  byte to enqueue, sampled when the strobe is high.
- `tx`  out  1  serial line, idle high.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `busy`  out  1  a frame is on the line (state ≠ IDLE).
- `overflow`  out  1  sticky: a push was dropped; cleared only by reset.

## Operation
- FIFO: circular buffer, write/read pointers DEPTH_LOG2+1 bits wide (extra wrap bit), so full = MSBs differ and low bits equal, empty = pointers equal. Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Push while full with no pop in the same cycle: byte dropped, `overflow` set, pointers unchanged.
- Push and pop in the same cycle: both take effect; a push is accepted when full if a pop occurs that cycle; the count is unchanged.
- Push while empty and idle: byte is written; the pop happens no earlier than the next cycle, with no bypass path.
- FSM states are IDLE, START, DATA, STOP; bit-time counter `cnt` runs from CLK_PER_BIT−1 down to 0; `bitidx` runs 0..7.
  - IDLE: `tx`=1. If not empty, pop the head into the shift register, load `cnt`, and go to START.
  - START: `tx`=0 for CLK_PER_BIT cycles, then go to DATA with `bitidx`=0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLK_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP (or PARITY, see Configuration).
  - STOP: `tx`=1 for CLK_PER_BIT cycles. At expiry, if not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- `tx` is registered: it changes only on clock edges and never glitches.
- Reset mid-frame aborts the frame immediately. `tx` returns to 1, the FIFO is flushed, and the partial frame is lost.

## Timing
- Reset values: `tx`=1, `full`=0, `empty`=1, `busy`=0, `overflow`=0, state IDLE, pointers 0, `cnt`=0.
- `full`/`empty` are registered-pointer derived and valid the cycle after the edge that changes the pointers.
- Latency: a push sampled at edge E0 into an empty, idle block makes `tx` fall at edge E0+2.
- `busy` rises with `tx` falling.
- Frame length is exactly 10×CLK_PER_BIT cycles, or 11×CLK_PER_BIT cycles with parity.
- Back-to-back queued bytes are separated by exactly one stop bit.
- `overflow` rises on the edge after the dropped push.

## Configuration
- `RS232C_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles, giving 8E1 frames.
- Undefined: no PARITY state and no parity logic; frames are 8N1.

## Test plan
- Reset: hold `rst_n`=0 → `tx`=1, `empty`=1, `full`=0, `busy`=0, `overflow`=0; release → no activity.
- Single byte 0x55, CLK_PER_BIT=4 → `tx` falls 2 cycles after the push; the line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 cycles each, then idle high.
- Burst of 3 bytes 0xA5, 0x00, 0xFF on consecutive cycles → three contiguous frames with no gap between the stop of one and the start of the next; `empty`=1 after the third pop.
- Push 17 bytes while the first frame is still transmitting (depth 16) → `full`=1; the 18th push is dropped and `overflow`=1. The transmitted sequence matches the first 17 pushed bytes in order; no dropped byte appears.
- Push on the same cycle as a pop while full → the byte is accepted, `full` stays 1, `overflow` stays 0.
- Assert `rst_n` mid-DATA of 0x3C → `tx`=1 asynchronously, FIFO empty, and no remnant frame after release. With `RS232C_TX_PARITY_EN`, byte 0x07 carries parity bit 1 and 0x03 carries 0.
